// File: rtl/riscv16_rf_pkg.sv
// Shared register-file definitions: widths, the zero register and the bank write-port bundle.
package riscv16_rf_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int WORD_W     = 16;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 4'b0000;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [WORD_W-1:0]     data;
  } rf_wr_port_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard for in-flight long-latency ops, with the ID hazard compare.
module rf_scoreboard
  import riscv16_rf_pkg::*;
#(
  parameter int reg_bank_size = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue,
  input  logic [REG_ADDR_W-1:0] issue_addr,
  input  logic                  clear,
  input  logic [REG_ADDR_W-1:0] clear_addr,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] rs_one_addr,
  input  logic [REG_ADDR_W-1:0] rs_two_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  stall
);

  logic [reg_bank_size-1:0] pending;
  logic [reg_bank_size-1:0] pending_next;
  logic                     set;

  assign stall = ~rst & id_valid &
                 (pending[rs_one_addr] | pending[rs_two_addr] | pending[rd_addr]);

  // An issue seen while ID is stalled is dropped; ID re-presents it later.
  assign set = issue & ~stall & (issue_addr != REG_ZERO);

  // Set is applied after clear so it wins on a same-register collision.
  always_comb begin
    pending_next = pending;
    if (clear) pending_next[clear_addr] = 1'b0;
    if (set)   pending_next[issue_addr] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_next;
  end

endmodule

// File: rtl/regbank_write_scheduler.sv
// Arbitrates the register bank's single write port between WB and the long-latency unit,
// with a starvation counter that forces one LL grant after a bounded wait.
module regbank_write_scheduler
  import riscv16_rf_pkg::*;
#(
  parameter int reg_bank_size = 16,
  parameter int word_size     = 16,
  parameter int starve_limit  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wbValid,
  input  logic [REG_ADDR_W-1:0] wbAddr,
  input  logic [word_size-1:0]  wbData,
  output logic                  stallWB,
  input  logic                  llValid,
  input  logic [REG_ADDR_W-1:0] llAddr,
  input  logic [word_size-1:0]  llData,
  output logic                  llReady,
  input  logic                  llIssue,
  input  logic [REG_ADDR_W-1:0] llIssueAddr,
  input  logic                  idValid,
  input  logic [REG_ADDR_W-1:0] idRSOneAddr,
  input  logic [REG_ADDR_W-1:0] idRSTwoAddr,
  input  logic [REG_ADDR_W-1:0] idRDAddr,
  output logic                  stallID,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] regRD_addr,
  output logic [word_size-1:0]  regRD_data
);

  localparam logic [3:0] STARVE_MAX = 4'(starve_limit);

  logic        [3:0] starve_cnt;
  logic              force_ll;
  logic              grant_ll;
  logic              grant_wb;
  rf_wr_port_t       wr_port;

  assign force_ll = llValid & (starve_cnt == STARVE_MAX);
  assign grant_ll = ~rst & llValid & (~wbValid | force_ll);
  assign grant_wb = ~rst & wbValid & ~grant_ll;

  assign stallWB = ~rst & wbValid & force_ll;
  assign llReady = grant_ll;

  // R0 writes are still consumed/handshaken, they just never assert we.
  always_comb begin
    wr_port = '0;
    if (grant_ll) begin
      wr_port.addr = llAddr;
      wr_port.data = llData;
    end else if (grant_wb) begin
      wr_port.addr = wbAddr;
      wr_port.data = wbData;
    end
    wr_port.we = (grant_ll | grant_wb) & (wr_port.addr != REG_ZERO);
  end

  assign we         = wr_port.we;
  assign regRD_addr = wr_port.addr;
  assign regRD_data = wr_port.data;

  always_ff @(posedge clk) begin
    if (rst)                       starve_cnt <= '0;
    else if (~llValid | grant_ll)  starve_cnt <= '0;
    else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 4'd1;
  end

  rf_scoreboard #(
    .reg_bank_size(reg_bank_size)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue      (llIssue),
    .issue_addr (llIssueAddr),
    .clear      (grant_ll),
    .clear_addr (llAddr),
    .id_valid   (idValid),
    .rs_one_addr(idRSOneAddr),
    .rs_two_addr(idRSTwoAddr),
    .rd_addr    (idRDAddr),
    .stall      (stallID)
  );

endmodule

// File: doc/regbank_write_scheduler.md
# regbank_write_scheduler

Owns the single write port of `register_bank` and arbitrates it between the pipeline WB stage and an out-of-order long-latency (LL) unit (memory load return or multi-cycle ALU). A per-register scoreboard tracks destinations of in-flight LL ops and stalls ID on RAW/WAW hazards against them. A starvation counter guarantees LL forward progress by freezing WB for one cycle. The block sits between WB and the LL result bus on one side and `register_bank` (`we`, `regRD_addr`, `regRD_data`) on the other.

## Interface
- `reg_bank_size`, 16: number of architectural registers; R0 is hardwired zero.
- `word_size`, 16: data width.
- `starve_limit`, 4: number of consecutive cycles an LL result may wait before a forced grant (1..15).

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `wbValid`  in  1  WB stage holds a result to write.
- `wbAddr`  in  4  WB destination register.
- `wbData`  in  16  WB result.
- `stallWB`  out  1  WB must hold `wbValid`/`wbAddr`/`wbData` next cycle.
- `llValid`  in  1  LL result offered.
- `llAddr`  in  4  LL destination register.
- `llData`  in  16  LL result.
- `llReady`  out  1  LL result written this cycle; handshake completes on `llValid & llReady`.
- `llIssue`  in  1  ID issues an LL op this cycle.
- `llIssueAddr`  in  4  destination register of the issuing LL op.
- `idValid`  in  1  ID holds a valid instruction.
- `idRSOneAddr`, `idRSTwoAddr`, `idRDAddr`  in  4 each  ID source and destination registers.
- `stallID`  out  1  ID hazard against a pending LL destination.
- `we`, `regRD_addr`, `regRD_data`  out  1/4/16  register bank write port.

## Operation
- Scoreboard: `pending[reg_bank_size-1:0]`. Bit 0 is constant 0.
- Set: `pending[llIssueAddr]` is set on `llIssue & ~stallID & llIssueAddr!=0`. `llIssue` during `stallID` is ignored, and ID must re-present it.
- Clear: `pending[llAddr]` is cleared on an LL handshake.
- `stallID = idValid & (pending[idRSOneAddr] | pending[idRSTwoAddr] | pending[idRDAddr])`. It uses the registered `pending`, so it is conservative.
- A set and a clear of the same register in one cycle cannot occur, because the WAW stall prevents it. If it happens anyway, set wins.
- Arbitration, evaluated each cycle:
  - `forceLL = llValid & (starveCnt == starve_limit)`.
  - Grant LL when `llValid & (~wbValid | forceLL)`. Otherwise grant WB when `wbValid`.
  - `stallWB = wbValid & forceLL`.
- Write port, combinational: LL grant drives `llAddr`/`llData`. WB grant drives `wbAddr`/`wbData`. `we` = any grant and address != 0.
  - An LL result to R0 still handshakes.
  - A WB result to R0 is consumed with `we=0`.
- `llReady` = LL grant.
- `starveCnt` (4 bits):
  - Reset to 0 on an LL handshake or when `~llValid`.
  - Incremented when `llValid & ~llReady`.
  - Saturates at `starve_limit`.
- Reset (`rst` high), forced in the same cycle:
  - `we=0`, `llReady=0`, `stallWB=0`, `stallID=0`.
  - `pending` is cleared and `starveCnt=0` at the edge.
- Reset mid-operation drops all pending bits. An LL result arriving after reset is accepted and written normally.

## Timing
- Write path is zero-latency. `we`/`regRD_*` are combinational from the inputs in the same cycle, consistent with the bank's same-cycle forwarding.
- `pending` and `starveCnt` update at the rising edge. `stallID` reflects an issue or clear from the next cycle onward.
- LL waits at most `starve_limit` cycles behind continuous WB traffic, then wins for exactly one cycle. The stalled WB result is written on the following cycle, unless another LL is forced, which cannot occur because the counter restarts at 0.
- Minimum LL issue-to-consumer latency: issue in cycle N, `stallID` high from N+1 until the cycle after the handshake.

## Structure
- Shared package `riscv16_rf_pkg` holds:
  - `REG_ADDR_W=4` and `WORD_W=16`.
  - `REG_ZERO=4'b0000`.
  - The write-port struct/typedef (`we`, `addr`, `data`) reused by `register_bank` callers.
- Sub-module `rf_scoreboard` holds the pending vector with its set/clear/reset logic and the three-way hazard compare. The arbiter and starvation counter stay in the top module.

## Test plan
- Reset: assert `rst` with `llValid=1`, `wbValid=1` → `we=0`, `llReady=0`. One cycle after release, `pending==0` and `starveCnt==0`.
- Idle LL grant: `wbValid=0`, `llValid=1`, `llAddr=5`, `llData=16'hBEEF` → same cycle `we=1`, `regRD_addr=5`, `regRD_data=16'hBEEF`, `llReady=1`.
- Priority/starvation: `starve_limit=4`, `wbValid` held 1 and `llValid` held 1 → WB is written for 4 cycles. Cycle 5: LL is written and `stallWB=1`. Cycle 6: the held WB value is written.
- Hazard: `llIssue` to x3 at cycle 0. At cycle 1, ID has `idRSOneAddr=3` → `stallID=1` until the LL x3 handshake; `stallID=0` the cycle after.
- R0: `llIssueAddr=0` → no pending bit. `wbAddr=0`, `wbValid=1` → `we=0`. `llAddr=0` → `llReady=1`, `we=0`.
- WAW: x7 pending and ID has `idRDAddr=7` with `llIssue=1` → `stallID=1` and the issue is ignored (pending is unchanged after the handshake clears it).
